// File: rtl/and_cosim_sched.sv
// Round-robin scheduler sharing one co-simulated AND-gate evaluation port
// among NREQ requesters. One transaction in flight: accept, issue, wait for
// completion or timeout, then pulse the response to the granted requester.
module and_cosim_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_y,
  output logic            rsp_err,
  output logic            eval_start,
  output logic            eval_a,
  output logic            eval_b,
  input  logic            eval_done,
  input  logic            eval_y,
  output logic            busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   idx_q;
  logic [WW-1:0]   wcnt_q;
  logic            res_q;
  logic            err_q;
  logic            a_q;
  logic            b_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [IW-1:0]   ptr_next;
  int unsigned     scan_j;

  // Round-robin pick: first valid requester at or above ptr, wrapping to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_j    = 0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      scan_j = 32'(ptr_q) + o;
      if (scan_j >= NREQ) begin
        scan_j = scan_j - NREQ;
      end
      if (!grant_any && req_valid[scan_j]) begin
        grant_any = 1'b1;
        grant_idx = IW'(scan_j);
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the requester just served.
  always_comb begin
    ptr_next = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
  end

  // Outputs: req_ready is the only combinational path; the rest decode state.
  always_comb begin
    req_ready  = (state_q == StIdle) ? grant : '0;
    rsp_valid  = '0;
    if (state_q == StResp) begin
      rsp_valid[idx_q] = 1'b1;
    end
    rsp_y      = res_q;
    rsp_err    = err_q;
    eval_start = (state_q == StIssue);
    eval_a     = a_q;
    eval_b     = b_q;
    busy       = (state_q != StIdle);
  end

  // Transaction FSM with its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            idx_q   <= grant_idx;
            a_q     <= req_a[grant_idx];
            b_q     <= req_b[grant_idx];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          wcnt_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A completion on the final wait cycle still beats the timeout.
          if (eval_done) begin
            res_q   <= eval_y;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
            res_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        StResp: begin
          ptr_q   <= ptr_next;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_and_cosim_sched.sv
// Scoreboard bench for and_cosim_sched: a transaction-level model predicts
// grants, latencies and results; a negedge monitor checks the DUT.
module tb_and_cosim_sched;

  localparam int NREQ = 4;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_a, req_b, req_ready, rsp_valid;
  logic            rsp_y, rsp_err, eval_start, eval_a, eval_b, eval_done, eval_y, busy;

  and_cosim_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_y      (rsp_y),
    .rsp_err    (rsp_err),
    .eval_start (eval_start),
    .eval_a     (eval_a),
    .eval_b     (eval_b),
    .eval_done  (eval_done),
    .eval_y     (eval_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic y;
    logic err;
    int   due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_err    = 0;

  // Model state (transaction level).
  int              cyc = 0;
  int              mptr = 0;
  int              next_idle = 0;
  int              issue_cyc = -1;
  int              wlo = -1, whi = -1, cur_due = -1;
  int              done_at = -1;
  logic            done_y = 1'b0;
  logic [NREQ-1:0] pend = '0, pa = '0, pb = '0;
  int              force_k = 0;
  bit              rand_mode = 0, refill = 0, mon_en = 0;

  // Per-cycle expectations for the monitor.
  logic [NREQ-1:0] exp_ready = '0;
  logic            exp_busy = 1'b0, exp_start = 1'b0, exp_a = 1'b0, exp_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int o = 0; o < NREQ; o++) begin
      int j;
      j = (p + o) % NREQ;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  // Advance one cycle: drive inputs, predict grant and transaction outcome.
  task automatic step();
    int   g, k;
    logic y;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if ($urandom_range(19, 0) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = 1'($urandom);
          pb[i]   = 1'($urandom);
        end
      end
    end
    exp_busy  = (cyc < next_idle);
    exp_start = (cyc == issue_cyc);
    if (cyc == done_at) begin
      eval_done = 1'b1;
      eval_y    = done_y;
    end else if (cyc >= wlo && cyc <= whi) begin
      eval_done = 1'b0;
      eval_y    = 1'($urandom);
    end else begin
      // Outside the wait window completions are stale and must be ignored.
      eval_done = rand_mode && ($urandom_range(3, 0) == 0);
      eval_y    = 1'($urandom);
    end
    req_valid = pend;
    req_a     = pa;
    req_b     = pb;
    exp_ready = '0;
    if (!exp_busy && pend != '0) begin
      g            = pick(pend, mptr);
      exp_ready[g] = 1'b1;
      k            = (force_k > 0) ? force_k : int'($urandom_range(TO + 3, 1));
      y            = (force_k > 0) ? (pa[g] & pb[g]) : 1'($urandom);
      exp_a        = pa[g];
      exp_b        = pb[g];
      e.idx        = g;
      e.err        = (k > TO);
      e.y          = e.err ? 1'b0 : y;
      e.due        = cyc + 2 + ((k > TO) ? TO : k);
      sb.push_back(e);
      issue_cyc = cyc + 1;
      wlo       = cyc + 2;
      whi       = e.due - 1;
      cur_due   = e.due;
      next_idle = e.due + 1;
      done_at   = cyc + 1 + k;
      done_y    = y;
      mptr      = (g + 1) % NREQ;
      if (refill) begin
        pa[g] = 1'($urandom);
        pb[g] = 1'($urandom);
      end else begin
        pend[g] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse between clock edges; aborts any transaction.
  task automatic mid_reset();
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    eval_done = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eval_start", 32'(eval_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    sb.delete();
    next_idle = cyc;
    mptr      = 0;
    issue_cyc = -1;
    wlo       = -1;
    whi       = -1;
    cur_due   = -1;
    done_at   = -1;
    exp_ready = '0;
    exp_busy  = 1'b0;
    exp_start = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare handshake/status every cycle, pop scoreboard on responses.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("eval_start", 32'(eval_start), 32'(exp_start));
      if (exp_busy && cyc < cur_due) begin
        chk("eval_a", 32'(eval_a), 32'(exp_a));
        chk("eval_b", 32'(eval_b), 32'(exp_b));
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++;
        n_err++;
        $display("FAIL rsp_missing @cyc %0d: got none expected rsp for req%0d at cyc %0d",
                 cyc, sb[0].idx, sb[0].due);
        void'(sb.pop_front());
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rsp_unexpected @cyc %0d: got rsp_valid %0h expected 0", cyc, rsp_valid);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.idx);
          chk("rsp_y", 32'(rsp_y), 32'(mon_e.y));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_cycle", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    req_a     = '0;
    req_b     = '0;
    eval_done = 1'b0;
    eval_y    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_eval_start", 32'(eval_start), 0);
    chk("reset_eval_ab", 32'({eval_a, eval_b}), 0);
    chk("reset_rsp", 32'({rsp_valid, rsp_y, rsp_err}), 0);
    chk("reset_ready_from_ptr0", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;
    rst_n     = 1'b1;
    mon_en    = 1;

    // Round robin with all requesters held high: order 0,1,2,3,0.
    pend = 4'b1111; pa = 4'b1010; pb = 4'b1100; refill = 1; force_k = 1;
    run(18);
    refill = 0; pend = '0;
    run(6);

    // Single request, fast completion.
    pend[0] = 1'b1; pa[0] = 1'b1; pb[0] = 1'b1;
    run(8);

    // Timeout with a late stale completion at T+20.
    force_k = TO + 5;
    pend[1] = 1'b1; pa[1] = 1'b1; pb[1] = 1'b1;
    run(26);

    // Completion on the last wait cycle beats the timeout.
    force_k = TO;
    pend[2] = 1'b1; pa[2] = 1'b1; pb[2] = 1'b1;
    run(22);

    // Pointer wrap: serve req3, then 1001 must grant req0.
    force_k = 1;
    pend[3] = 1'b1; pa[3] = 1'b1; pb[3] = 1'b0;
    run(6);
    pend = 4'b1001; pa = 4'b1001; pb = 4'b0001;
    run(12);

    // Reset mid-WAIT: aborted request gets no response, next grant req0.
    force_k = TO + 3;
    pend[2] = 1'b1; pa[2] = 1'b0; pb[2] = 1'b1;
    run(5);
    mid_reset();
    force_k = 2;
    pend = 4'b1001; pa = 4'b0001; pb = 4'b0001;
    run(16);

    // Withdrawal: req2 drops its request before being accepted.
    force_k = 8;
    pend[0] = 1'b1; pa[0] = 1'b1; pb[0] = 1'b1;
    run(1);
    pend[2] = 1'b1; pa[2] = 1'b1; pb[2] = 1'b1;
    run(3);
    pend[2] = 1'b0;
    run(15);

    // Randomized traffic with stale completions and timeouts.
    force_k   = 0;
    rand_mode = 1;
    run(3000);
    rand_mode = 0;
    pend      = '0;
    run(TO + 10);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
